// File: rtl/ks_arith_pkg.sv
// Shared definitions for the digit-serial Kogge-Stone arithmetic units:
// digit width, controller state encoding and digit-count helpers.
package ks_arith_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of DIGIT_W-bit digits in an operand of the given width.
  function automatic int ndig_of(input int width);
    return width / DIGIT_W;
  endfunction

  // Width of a counter that indexes ndig digits; never narrower than one bit.
  function automatic int cnt_w_of(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/ks_sub_digit.sv
// Combinational 4-bit subtract slice: d4 = a4 + ~b4 + cin, where cin is the
// inverted incoming borrow. Carries come from a 4-bit Kogge-Stone
// generate/propagate prefix tree with cin folded into bit 0's generate.
// c_msb_in is the carry into bit 3, used by the top level for signed overflow.
module ks_sub_digit
  import ks_arith_pkg::*;
(
  input  logic [DIGIT_W-1:0] a4,
  input  logic [DIGIT_W-1:0] b4,
  input  logic               cin,
  output logic [DIGIT_W-1:0] d4,
  output logic               cout,
  output logic               c_msb_in
);

  logic [3:0] b_inv;
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] g1;
  logic [3:2] p1;
  logic       g2_2;
  logic       g2_3;
  logic [3:0] c;

  // Bit-level generate/propagate on the inverted subtrahend.
  assign b_inv = ~b4;
  assign g     = a4 & b_inv;
  assign p     = a4 ^ b_inv;

  // Prefix level 1 (span 2); bit 0 absorbs the carry-in so every group that
  // reaches bit 0 is already a complete carry.
  assign g1[0] = g[0] | (p[0] & cin);
  assign g1[1] = g[1] | (p[1] & g1[0]);
  assign g1[2] = g[2] | (p[2] & g[1]);
  assign g1[3] = g[3] | (p[3] & g[2]);
  assign p1[2] = p[2] & p[1];
  assign p1[3] = p[3] & p[2];

  // Prefix level 2 (span 4).
  assign g2_2 = g1[2] | (p1[2] & g1[0]);
  assign g2_3 = g1[3] | (p1[3] & g1[1]);

  // Carry into each bit position, then the sum bits.
  assign c        = {g2_2, g1[1], g1[0], cin};
  assign d4       = p ^ c;
  assign cout     = g2_3;
  assign c_msb_in = g2_2;

endmodule

// File: rtl/ks_serial_subtractor.sv
// Digit-serial subtractor: diff = (a - b - bin) mod 2^WIDTH, processed one
// 4-bit digit per cycle, LSB digit first, with a valid/ready handshake on
// each side and one operation in flight. The carry register holds the
// inverted borrow between digits; bout is the inverted final carry.
// Optional signed-overflow output: define KS_SERIAL_SUB_OVF_EN.
module ks_serial_subtractor
  import ks_arith_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef KS_SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NDIG  = ndig_of(WIDTH);
  localparam int CNT_W = cnt_w_of(NDIG);
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  if (((WIDTH % DIGIT_W) != 0) || (WIDTH < DIGIT_W)) begin : g_bad_width
    $error("ks_serial_subtractor: WIDTH must be a multiple of 4 and at least 4");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
`ifdef KS_SERIAL_SUB_OVF_EN
  logic               ovf_q, ovf_d;
  logic               dig_cmsb;
`endif

  logic [DIGIT_W-1:0] dig_d;
  logic               dig_cout;

  // The current digit is always the low nibble of the shifting operands.
  ks_sub_digit u_digit (
    .a4       (a_q[DIGIT_W-1:0]),
    .b4       (b_q[DIGIT_W-1:0]),
    .cin      (carry_q),
    .d4       (dig_d),
    .cout     (dig_cout),
`ifdef KS_SERIAL_SUB_OVF_EN
    .c_msb_in (dig_cmsb)
`else
    .c_msb_in ()
`endif
  );

  // Next-state logic: accept in IDLE, one digit per BUSY cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef KS_SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = BUSY;
          a_d     = a;
          b_d     = b;
          carry_d = ~bin;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        a_d     = a_q >> DIGIT_W;
        b_d     = b_q >> DIGIT_W;
        carry_d = dig_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        for (int k = 0; k < NDIG; k++) begin
          if (cnt_q == CNT_W'(k)) begin
            diff_d[k*DIGIT_W +: DIGIT_W] = dig_d;
          end
        end
        if (cnt_q == LAST_DIG) begin
          state_d = DONE;
          cnt_d   = '0;
          bout_d  = ~dig_cout;
`ifdef KS_SERIAL_SUB_OVF_EN
          ovf_d   = dig_cmsb ^ dig_cout;
`endif
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef KS_SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef KS_SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
`ifdef KS_SERIAL_SUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_ks_serial_subtractor.sv
// Directed-vector bench for ks_serial_subtractor (WIDTH=16).
module tb_ks_serial_subtractor;

  localparam int W    = 16;
  localparam int NDIG = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
`ifdef KS_SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ks_serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef KS_SERIAL_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // Drive one operation, scramble operands after the accept edge, wait
  // (bounded) for out_valid, capture results, hold for `hold` cycles, hand off.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                       input int hold, output int lat, output logic [W-1:0] od,
                       output logic ob, output logic oo);
    @(negedge clk);
    a = ta; b = tb; bin = tbin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~ta; b = ~tb; bin = ~tbin;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    od = diff; ob = bout;
`ifdef KS_SERIAL_SUB_OVF_EN
    oo = ovf;
`else
    oo = 1'b0;
`endif
    repeat (hold) @(posedge clk);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({in_ready, out_valid, bout, diff} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      n_err++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b bout=%b diff=%h, want 1 0 0 0000",
               in_ready, out_valid, bout, diff);
    end
`ifdef KS_SERIAL_SUB_OVF_EN
    n_vec++;
    if (ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ovf: got %b want 0", ovf);
    end
`endif
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL idle_after_reset: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [8] = '{16'h1234, 16'h0000, 16'h8000, 16'h0005, 16'h7FFF, 16'hFFFF, 16'h0003, 16'hABCD};
    logic [W-1:0] vb [8] = '{16'h0234, 16'h0001, 16'h7FFF, 16'h0003, 16'hFFFF, 16'h0000, 16'h0003, 16'h1234};
    logic         vi [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] vd [8] = '{16'h1000, 16'hFFFF, 16'h0000, 16'h0001, 16'h8000, 16'hFFFF, 16'hFFFF, 16'h9999};
    logic         vo [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic         vv [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int lat;
    logic [W-1:0] d;
    logic bo, ov;
    for (int i = 0; i < 8; i++) begin
      do_op(va[i], vb[i], vi[i], 0, lat, d, bo, ov);
      n_vec++;
      if (lat !== NDIG) begin
        n_err++;
        $display("FAIL latency[%0d]: got %0d want %0d", i, lat, NDIG);
      end
      n_vec++;
      if (d !== vd[i]) begin
        n_err++;
        $display("FAIL diff[%0d]: got %h want %h", i, d, vd[i]);
      end
      n_vec++;
      if (bo !== vo[i]) begin
        n_err++;
        $display("FAIL bout[%0d]: got %b want %b", i, bo, vo[i]);
      end
`ifdef KS_SERIAL_SUB_OVF_EN
      n_vec++;
      if (ov !== vv[i]) begin
        n_err++;
        $display("FAIL ovf[%0d]: got %b want %b", i, ov, vv[i]);
      end
`else
      if (ov !== 1'b0 && vv[i] === 1'bx) $display("unreachable");
`endif
    end
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk);
    a = 16'h1234; b = 16'h0234; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    n_vec++;
    if (lat !== NDIG) begin
      n_err++;
      $display("FAIL bp_latency: got %0d want %0d", lat, NDIG);
    end
    // Stall 10 cycles while offering a second operation.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a = 16'h0F0F; b = 16'h0101; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if ({out_valid, in_ready, bout, diff} !== {1'b1, 1'b0, 1'b0, 16'h1000}) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b bout=%b diff=%h, want 1 0 0 1000",
                 i, out_valid, in_ready, bout, diff);
      end
    end
    // Release: handoff edge must not also accept the pending operands.
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    n_vec++;
    if ({out_valid, in_ready, diff} !== {1'b0, 1'b1, 16'h1000}) begin
      n_err++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b diff=%h, want 0 1 1000",
               out_valid, in_ready, diff);
    end
    // Still-asserted in_valid is accepted on the next edge.
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_next_accept: in_ready=%b want 0", in_ready);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    n_vec++;
    if ({lat == NDIG, bout, diff} !== {1'b1, 1'b0, 16'h0E0E}) begin
      n_err++;
      $display("FAIL bp_next_result: lat=%0d bout=%b diff=%h, want lat=%0d 0 0e0e",
               lat, bout, diff, NDIG);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    logic seen;
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({in_ready, out_valid, bout, diff} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      n_err++;
      $display("FAIL midop_reset: in_ready=%b out_valid=%b bout=%b diff=%h, want 1 0 0 0000",
               in_ready, out_valid, bout, diff);
    end
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (3 * NDIG) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL midop_no_result: out_valid pulse seen=%b want 0", seen);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb, d, ed;
    logic ri, bo, ov, eb, eo;
    logic [W:0] full;
    int lat, r;
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom); rb = W'($urandom); ri = 1'($urandom);
      full = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, ri};
      ed = full[W-1:0];
      eb = full[W];
      r  = int'($signed(ra)) - int'($signed(rb)) - int'(ri);
      eo = (r < -32768 || r > 32767);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      do_op(ra, rb, ri, $urandom_range(0, 3), lat, d, bo, ov);
      n_vec++;
      if ({lat == NDIG, bo, d} !== {1'b1, eb, ed}) begin
        n_err++;
        $display("FAIL rand[%0d] %h-%h-%b: lat=%0d bout=%b diff=%h, want lat=%0d bout=%b diff=%h",
                 i, ra, rb, ri, lat, bo, d, NDIG, eb, ed);
      end
`ifdef KS_SERIAL_SUB_OVF_EN
      n_vec++;
      if (ov !== eo) begin
        n_err++;
        $display("FAIL rand_ovf[%0d]: got %b want %b", i, ov, eo);
      end
`else
      if (ov !== 1'b0 && eo === 1'bx) $display("unreachable");
`endif
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
